// File: rtl/serial_logic16.sv
// Bit-serial 16-bit logic unit: NOT/AND/OR/XOR evaluated LSB first through one
// 1-bit gate slice, with valid/ready handshakes on both the operand and result sides.
module serial_logic16 (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_r;
    logic [15:0] sa_r;
    logic [15:0] sb_r;
    logic [15:0] sr_r;
    logic [3:0]  cnt_r;
    logic [1:0]  opr_r;
    logic [15:0] out_r;
    logic        out_valid_r;
    logic        idle_r;
    logic        bit_s;
    logic [15:0] next_sr_s;

    // The single gate slice shared by every bit position.
    function automatic logic gate_bit(input logic [1:0] f_op, input logic x, input logic y);
        logic r;
        case (f_op)
            2'b00:   r = ~x;
            2'b01:   r = x & y;
            2'b10:   r = x | y;
            2'b11:   r = x ^ y;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Current result bit and the result shift register after inserting it at the MSB.
    always_comb begin
        bit_s     = gate_bit(opr_r, sa_r[0], sb_r[0]);
        next_sr_s = {bit_s, sr_r[15:1]};
    end

    // Handshake outputs; in_ready is forced low combinationally while reset is held.
    assign in_ready  = idle_r & ~reset;
    assign out_valid = out_valid_r;
    assign out       = out_r;

    // Control FSM and serial datapath; idle_r/out_valid_r track the state as flops.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= IDLE;
            sa_r        <= 16'h0000;
            sb_r        <= 16'h0000;
            sr_r        <= 16'h0000;
            cnt_r       <= 4'd0;
            opr_r       <= 2'b00;
            out_r       <= 16'h0000;
            out_valid_r <= 1'b0;
            idle_r      <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        sa_r    <= a;
                        sb_r    <= b;
                        opr_r   <= op;
                        cnt_r   <= 4'd0;
                        state_r <= SHIFT;
                        idle_r  <= 1'b0;
                    end else begin
                        state_r <= IDLE;
                        idle_r  <= 1'b1;
                    end
                end
                SHIFT: begin
                    sr_r  <= next_sr_s;
                    sa_r  <= {1'b0, sa_r[15:1]};
                    sb_r  <= {1'b0, sb_r[15:1]};
                    cnt_r <= cnt_r + 4'd1;
                    // The final bit goes straight into out so the result is complete on entry to DONE.
                    if (cnt_r == 4'd15) begin
                        out_r       <= next_sr_s;
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        state_r <= SHIFT;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        idle_r      <= 1'b1;
                        state_r     <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                    idle_r      <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/serial_logic16.md
# serial_logic16

Bit-serial 16-bit logic unit: accepts two 16-bit operands and an opcode through a valid/ready handshake, evaluates NOT/AND/OR/XOR one bit per clock (LSB first) with a single 1-bit gate slice, and returns the 16-bit result through a second valid/ready handshake. It is the serial, area-minimal counterpart to the parallel 16-bit gate modules. It is used where a wide parallel datapath is not wanted, for example in a multi-cycle CPU variant.

## Interface
- Parameters: none; the width is fixed at 16.
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand/opcode presented.
- in_ready  output  1  block can accept; equals (state == IDLE) && !reset.
- op  input  2  operation code:
  - 00: NOT a (b ignored)
  - 01: a AND b
  - 10: a OR b
  - 11: a XOR b
- a  input  16  operand A.
- b  input  16  operand B.
- out_valid  output  1  result available; equals (state == DONE).
- out_ready  input  1  consumer takes the result.
- out  output  16  result register.

## Operation
- States: IDLE, SHIFT, DONE.
- Internal registers:
  - sa, sb: 16-bit operand shift registers.
  - sr: 16-bit result shift register.
  - cnt: 4-bit bit counter.
  - opr: 2-bit captured opcode.
  - out: 16-bit result register.
- IDLE:
  - If in_valid, capture a→sa, b→sb, op→opr, clear cnt, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, each cycle:
  - bit = f(opr, sa[0], sb[0]).
  - sr <= {bit, sr[15:1]}; sa <= sa>>1; sb <= sb>>1; cnt <= cnt+1.
  - When cnt == 15: load out <= {bit, sr[15:1]} and go to DONE.
- DONE:
  - Hold out and out_valid.
  - If out_ready, go to IDLE. out keeps its value until the next completion.
- Operand and op input changes after acceptance have no effect on an operation in progress.
- in_valid outside IDLE is ignored; the producer must hold it until in_ready.
- out_ready outside DONE is ignored.
- No back-to-back overlap: a new operand cannot be accepted in the same cycle that a result is consumed.

## Timing
- Reset, on any edge with reset=1 and regardless of state (including mid-SHIFT or DONE):
  - state = IDLE; sa, sb, sr, out, cnt, opr cleared to 0.
  - out_valid = 0 and out = 16'h0000.
  - in_ready = 0 while reset is high, and 1 on the cycle after reset deasserts.
  - Any partial result is discarded and no out_valid pulse occurs.
- Acceptance edge E0: in_valid && in_ready.
- Edges E1..E16 process bits 0..15; cnt wraps 15→0 at E16.
- out_valid rises after E16: latency of 16 cycles from acceptance to result.
- Consumption edge: out_valid && out_ready, earliest at E17. in_ready rises after it.
- Earliest next acceptance is E18, so peak throughput is one operation per 18 cycles.
- out_valid stays high indefinitely under out_ready=0, with out stable.

## Test plan
- Reset, then AND with a=16'hF0F0, b=16'hFF00, in_valid held for one cycle → out_valid asserted exactly 16 cycles after acceptance; out=16'hF000; in_ready low throughout SHIFT/DONE.
- OR a=16'h00FF, b=16'h0F0F → 16'h0FFF. NOT a=16'h1234, b=16'hFFFF → 16'hEDCB. XOR a=16'hAAAA, b=16'hFFFF → 16'h5555.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → out_valid and out=16'hF000 unchanged. Meanwhile in_valid=1 with new operands is not accepted (in_ready=0). After out_ready=1, the new operand is accepted two edges later.
- Operand corruption: change a, b and op every cycle during SHIFT → result matches the operands captured at acceptance.
- Reset asserted at cnt=7 of an OR operation → next cycle out_valid=0 and out=16'h0000. After deassert, in_ready=1 and a fresh AND 16'hFFFF&16'h8001 returns 16'h8001.
- Back-to-back: 20 random operations with in_valid and out_ready held high → every result correct, spacing exactly 18 cycles.
